// File: rtl/max11043_pkg.sv
// Shared types and constants for the MAX11043 SPI controller.
package max11043_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL,
        GAP
    } state_e;

    localparam int unsigned WR_BITS   = 24;
    localparam int unsigned RD_BITS   = 64;
    localparam int unsigned CMD_BITS  = 8;
    // A read frame is the command byte followed by the four-channel result.
    localparam int unsigned SHIFT_W   = CMD_BITS + RD_BITS;
    localparam int unsigned BIT_CNT_W = $clog2(SHIFT_W + 1);

    localparam logic [CMD_BITS-1:0] RD_CMD_DEF = 8'h81;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: generates SCLK, shifts MOSI out MSB first and
// samples MISO for n_bits bits after a start strobe.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   start        - one-cycle strobe; loads load_data and n_bits
//   load_data    - frame, MSB-aligned; bits below the frame length must be 0
//   n_bits       - number of bits in the frame
//   miso         - serial data in
//   sclk, mosi   - serial clock and data out (registered)
//   done_c       - high in the last cycle of the last bit
//   rx_bits      - last RD_BITS sampled bits, earliest in the MSB
module spi_bit_engine
    import max11043_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SHIFT_W-1:0]   load_data,
    input  logic [BIT_CNT_W-1:0] n_bits,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 done_c,
    output logic [RD_BITS-1:0]   rx_bits
);

    localparam int unsigned DIV_W = 16;

    logic                 active;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] n_q;
    logic [SHIFT_W-1:0]   tx_sr;
    logic                 phase_end_c;

    assign phase_end_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign done_c      = phase_end_c && sclk && (bit_cnt == n_q - BIT_CNT_W'(1));
    // MOSI is the shift register MSB; zeros shift in, so MOSI returns to 0 after the frame.
    assign mosi        = tx_sr[SHIFT_W-1];

    // Half-period divider, SCLK toggling, MISO sampling and MOSI shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            n_q     <= '0;
            tx_sr   <= '0;
            rx_bits <= '0;
            sclk    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            n_q     <= n_bits;
            tx_sr   <= load_data;
            sclk    <= 1'b0;
        end else if (phase_end_c) begin
            div_cnt <= '0;
            if (!sclk) begin
                sclk <= 1'b1;
            end else begin
                // End of high phase: sample, drop SCLK, advance MOSI.
                sclk    <= 1'b0;
                rx_bits <= {rx_bits[RD_BITS-2:0], miso};
                tx_sr   <= {tx_sr[SHIFT_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (done_c) begin
                    active <= 1'b0;
                end
            end
        end else if (active) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/max11043_spi_ctrl.sv
// SPI master for the MAX11043 ADC: sends 24-bit register writes from the
// host and reads the 64-bit four-channel result after every EOC.
// Ports:
//   CLK, RST  - system clock, synchronous active-high reset
//   EOC       - ADC end-of-conversion, active low, asynchronous
//   TX_READY  - level request to send DATAIN
//   DATAIN    - 24-bit command word, MSB first
//   MISO      - ADC DOUT
//   CS, SCLK, MOSI - SPI pins (mode 0, CS active low)
//   RX        - last read result, first received bit in RX[63]
//   RX_READY  - one-cycle pulse when RX updates
//   TX_SENT   - high when idle and able to accept a write
module max11043_spi_ctrl
    import max11043_pkg::*;
#(
    parameter int unsigned          CLK_DIV = 2,
    parameter int unsigned          CS_HIGH = 4,
    parameter logic [CMD_BITS-1:0]  RD_CMD  = RD_CMD_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EOC,
    input  logic                TX_READY,
    input  logic [WR_BITS-1:0]  DATAIN,
    input  logic                MISO,
    output logic                CS,
    output logic                SCLK,
    output logic                MOSI,
    output logic [RD_BITS-1:0]  RX,
    output logic                RX_READY,
    output logic                TX_SENT
);

    localparam int unsigned CNT_W = 16;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_mode_q, rd_mode_d;
    logic                 pend_q, pend_d;
    logic                 cs_d, tx_sent_d, rx_ready_d;
    logic [RD_BITS-1:0]   rx_d;

    logic                 eoc_meta, eoc_sync, eoc_prev;
    logic                 eoc_fall_c;

    logic                 start_c;
    logic [SHIFT_W-1:0]   load_c;
    logic [BIT_CNT_W-1:0] nbits_c;
    logic                 done_c;
    logic [RD_BITS-1:0]   rx_bits;

    assign eoc_fall_c = eoc_prev && !eoc_sync;

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (CLK),
        .rst       (RST),
        .start     (start_c),
        .load_data (load_c),
        .n_bits    (nbits_c),
        .miso      (MISO),
        .sclk      (SCLK),
        .mosi      (MOSI),
        .done_c    (done_c),
        .rx_bits   (rx_bits)
    );

    // Arbitration, CS tail/gap timing and RX capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_mode_d  = rd_mode_q;
        pend_d     = pend_q || eoc_fall_c;
        cs_d       = CS;
        tx_sent_d  = TX_SENT;
        rx_d       = RX;
        rx_ready_d = 1'b0;
        start_c    = 1'b0;
        load_c     = '0;
        nbits_c    = '0;

        case (state_q)
            IDLE: begin
                // A pending read always wins over a waiting write.
                if (pend_q) begin
                    start_c   = 1'b1;
                    load_c    = {RD_CMD, {RD_BITS{1'b0}}};
                    nbits_c   = BIT_CNT_W'(SHIFT_W);
                    rd_mode_d = 1'b1;
                    pend_d    = eoc_fall_c;
                    cs_d      = 1'b0;
                    tx_sent_d = 1'b0;
                    state_d   = SHIFT;
                end else if (TX_READY) begin
                    start_c   = 1'b1;
                    load_c    = {DATAIN, {(SHIFT_W - WR_BITS){1'b0}}};
                    nbits_c   = BIT_CNT_W'(WR_BITS);
                    rd_mode_d = 1'b0;
                    cs_d      = 1'b0;
                    tx_sent_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (done_c) begin
                    cnt_d   = '0;
                    state_d = TAIL;
                end
            end
            TAIL: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    state_d = GAP;
                    if (rd_mode_q) begin
                        rx_d       = rx_bits;
                        rx_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(CS_HIGH - 1)) begin
                    cnt_d     = '0;
                    tx_sent_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, outputs and EOC synchronizer (idles high so reset never looks like an edge).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_mode_q <= 1'b0;
            pend_q    <= 1'b0;
            CS        <= 1'b1;
            TX_SENT   <= 1'b1;
            RX        <= '0;
            RX_READY  <= 1'b0;
            eoc_meta  <= 1'b1;
            eoc_sync  <= 1'b1;
            eoc_prev  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_mode_q <= rd_mode_d;
            pend_q    <= pend_d;
            CS        <= cs_d;
            TX_SENT   <= tx_sent_d;
            RX        <= rx_d;
            RX_READY  <= rx_ready_d;
            eoc_meta  <= EOC;
            eoc_sync  <= eoc_meta;
            eoc_prev  <= eoc_sync;
        end
    end

endmodule

// File: tb/tb_max11043_spi_ctrl.sv
// Scoreboard bench for max11043_spi_ctrl: stimulus pushes expected frames,
// TX_SENT-low durations and RX results; a negedge monitor pops and compares.
module tb_max11043_spi_ctrl;

    localparam int CLK_DIV = 2;
    localparam int CS_HIGH = 4;
    localparam int WR_N    = 24;
    localparam int RD_N    = 72;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EOC = 1'b1;
    logic        TX_READY = 1'b0;
    logic [23:0] DATAIN = '0;
    logic        MISO = 1'b0;
    logic        CS, SCLK, MOSI, RX_READY, TX_SENT;
    logic [63:0] RX;

    typedef struct {
        int          nbits;
        logic [71:0] mosi;
        int          cs_len;
        bit          is_rd;
    } frame_t;

    frame_t      exp_q[$];
    int          dur_q[$];
    logic [63:0] rx_q[$];

    int          tests = 0;
    int          fails = 0;
    logic [63:0] adc_word = '0;
    logic [63:0] mdl_rx = '0;
    logic [7:0]  miso_hdr = 8'hA5;

    max11043_spi_ctrl #(
        .CLK_DIV (CLK_DIV),
        .CS_HIGH (CS_HIGH),
        .RD_CMD  (8'h81)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EOC      (EOC),
        .TX_READY (TX_READY),
        .DATAIN   (DATAIN),
        .MISO     (MISO),
        .CS       (CS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .RX       (RX),
        .RX_READY (RX_READY),
        .TX_SENT  (TX_SENT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: frame shape and timing from the protocol rules.
    task automatic push_write(input logic [23:0] d);
        frame_t f;
        f.nbits  = WR_N;
        f.mosi   = {d, 48'h0};
        f.cs_len = WR_N * 2 * CLK_DIV + CLK_DIV;
        f.is_rd  = 1'b0;
        exp_q.push_back(f);
        dur_q.push_back(f.cs_len + CS_HIGH);
    endtask

    task automatic push_read(input logic [63:0] w);
        frame_t f;
        f.nbits  = RD_N;
        f.mosi   = {8'h81, 64'h0};
        f.cs_len = RD_N * 2 * CLK_DIV + CLK_DIV;
        f.is_rd  = 1'b1;
        exp_q.push_back(f);
        dur_q.push_back(f.cs_len + CS_HIGH);
        rx_q.push_back(w);
    endtask

    task automatic wait_ts(input logic val, input int limit, input string name);
        int k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (TX_SENT !== val && k < limit);
        if (TX_SENT !== val) begin
            tests++;
            fails++;
            $display("FAIL %s: got TX_SENT=%b expected %b within %0d cycles", name, TX_SENT, val, limit);
        end
    endtask

    task automatic do_write(input logic [23:0] d);
        wait_ts(1'b1, 400, "wr_wait_idle");
        DATAIN   = d;
        TX_READY = 1'b1;
        push_write(d);
        wait_ts(1'b0, 10, "wr_start");
        TX_READY = 1'b0;
        DATAIN   = 24'($urandom);
    endtask

    task automatic eoc_pulse();
        EOC = 1'b0;
        repeat (3) @(negedge CLK);
        EOC = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || dur_q.size() != 0 || rx_q.size() != 0) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        if (exp_q.size() != 0 || dur_q.size() != 0 || rx_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d frames still expected, expected 0", exp_q.size());
            exp_q.delete();
            dur_q.delete();
            rx_q.delete();
        end
        repeat (20) @(negedge CLK);
    endtask

    // Monitor: SPI slave model, frame checker, TX_SENT timer and RX checker.
    bit          prev_cs, prev_sclk, prev_ts, in_frame, seen_frame;
    int          cs_len, n_rise, ts_len, gap_cnt;
    logic [71:0] mosi_cap, miso_sr;
    always @(negedge CLK) begin
        frame_t      f;
        logic [63:0] e;
        int          d;
        if (RST) begin
            in_frame   = 1'b0;
            seen_frame = 1'b0;
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            prev_ts    = 1'b1;
            ts_len     = 0;
            gap_cnt    = 0;
            mdl_rx     = '0;
            MISO       = 1'b0;
        end else begin
            if (prev_cs && !CS) begin
                if (seen_frame) chk("cs_gap_ok", 72'(gap_cnt >= CS_HIGH), 72'(1));
                in_frame = 1'b1;
                cs_len   = 0;
                n_rise   = 0;
                mosi_cap = '0;
                miso_sr  = {miso_hdr, adc_word};
                MISO     = miso_sr[71];
            end
            if (!CS && in_frame) begin
                cs_len++;
                if (!prev_sclk && SCLK) begin
                    mosi_cap = {mosi_cap[70:0], MOSI};
                    n_rise++;
                end
                if (prev_sclk && !SCLK) begin
                    miso_sr = {miso_sr[70:0], 1'b0};
                    MISO    = miso_sr[71];
                end
            end
            if (!prev_cs && CS && in_frame) begin
                in_frame   = 1'b0;
                seen_frame = 1'b1;
                gap_cnt    = 0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got %0d sclk pulses expected no transaction", n_rise);
                end else begin
                    f = exp_q.pop_front();
                    chk("sclk_pulses", 72'(n_rise), 72'(f.nbits));
                    if (n_rise > 0 && n_rise <= 72) mosi_cap = mosi_cap << (72 - n_rise);
                    chk("mosi_bits", mosi_cap, f.mosi);
                    chk("cs_low_cycles", 72'(cs_len), 72'(f.cs_len));
                    if (!f.is_rd) chk("rx_hold_on_write", {8'h0, RX}, {8'h0, mdl_rx});
                end
            end
            if (CS) gap_cnt++;
            if (!TX_SENT) begin
                if (prev_ts) ts_len = 0;
                ts_len++;
            end
            if (!prev_ts && TX_SENT) begin
                if (dur_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx_sent: got busy %0d cycles expected no transaction", ts_len);
                end else begin
                    d = dur_q.pop_front();
                    chk("tx_sent_low_cycles", 72'(ts_len), 72'(d));
                end
            end
            if (RX_READY) begin
                if (rx_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rx_ready: got RX=%0h expected no pulse", RX);
                end else begin
                    e = rx_q.pop_front();
                    chk("rx_value", {8'h0, RX}, {8'h0, e});
                    mdl_rx = e;
                end
            end
            prev_cs   = CS;
            prev_sclk = SCLK;
            prev_ts   = TX_SENT;
        end
    end

    initial begin
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_cs", 72'(CS), 72'(1));
        chk("rst_sclk", 72'(SCLK), 72'(0));
        chk("rst_mosi", 72'(MOSI), 72'(0));
        chk("rst_rx", {8'h0, RX}, 72'(0));
        chk("rst_rx_ready", 72'(RX_READY), 72'(0));
        chk("rst_tx_sent", 72'(TX_SENT), 72'(1));
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single write
        do_write(24'h30101B);
        wait_idle();

        // Single read
        adc_word = 64'h123456789ABCDEF0;
        push_read(adc_word);
        eoc_pulse();
        wait_idle();

        // EOC collides with a write; read goes ahead of a held TX_READY
        adc_word = {$urandom, $urandom};
        do_write(24'h34101B);
        repeat (9) @(negedge CLK);
        push_read(adc_word);
        EOC = 1'b0;
        repeat (3) @(negedge CLK);
        EOC = 1'b1;
        DATAIN   = 24'h38101B;
        TX_READY = 1'b1;
        push_write(24'h38101B);
        wait_ts(1'b1, 400, "coll_wr_end");
        wait_ts(1'b0, 10, "coll_rd_start");
        wait_ts(1'b1, 400, "coll_rd_end");
        wait_ts(1'b0, 10, "coll_wr2_start");
        TX_READY = 1'b0;
        wait_idle();

        // Back-to-back writes
        do_write(24'h30101B);
        do_write(24'h34101B);
        do_write(24'h38101B);
        do_write(24'h3C101B);
        wait_idle();

        // Two EOC edges during one transfer collapse into one read
        adc_word = {$urandom, $urandom};
        do_write(24'($urandom));
        push_read(adc_word);
        eoc_pulse();
        eoc_pulse();
        wait_idle();

        // Randomized mix
        for (int i = 0; i < 10; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            adc_word = {$urandom, $urandom};
            miso_hdr = 8'($urandom);
            if (sel == 0) begin
                do_write(24'($urandom));
            end else if (sel == 1) begin
                push_read(adc_word);
                eoc_pulse();
            end else begin
                do_write(24'($urandom));
                repeat ($urandom_range(1, 60)) @(negedge CLK);
                push_read(adc_word);
                eoc_pulse();
            end
            wait_idle();
        end

        // Reset in the middle of a read
        adc_word = 64'hFEDCBA9876543210;
        push_read(adc_word);
        eoc_pulse();
        wait_idle();
        adc_word = {$urandom, $urandom};
        eoc_pulse();
        wait_ts(1'b0, 20, "abort_rd_start");
        repeat (40) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_cs", 72'(CS), 72'(1));
        chk("midrst_sclk", 72'(SCLK), 72'(0));
        chk("midrst_mosi", 72'(MOSI), 72'(0));
        chk("midrst_rx", {8'h0, RX}, 72'(0));
        chk("midrst_tx_sent", 72'(TX_SENT), 72'(1));
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (400) @(negedge CLK);
        chk("post_rst_cs_idle", 72'(CS), 72'(1));
        chk("post_rst_rx", {8'h0, RX}, 72'(0));
        chk("post_rst_tx_sent", 72'(TX_SENT), 72'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/max11043_spi_ctrl.md
Name: max11043_spi_ctrl

Overview:
- SPI master for the MAX11043 4-channel ADC on the hydrophone board.
- Shifts 24-bit register-write commands (8-bit command + 16-bit data) from the host logic out to the ADC.
- On every end-of-conversion (EOC low) from the ADC, automatically reads the 64-bit four-channel result.
- Sits between the top-level command sequencer/FIFO and the ADC pins.

Parameters:
- CLK_DIV, 2: CLK cycles per SCLK half-period; SCLK = CLK/(2*CLK_DIV). Minimum 1.
- CS_HIGH, 4: minimum CLK cycles CS stays high between transactions.
- RD_CMD, 8'h81: command byte sent at the start of an EOC-triggered data read.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- EOC  in  1  ADC end-of-conversion, active low, asynchronous.
- TX_READY  in  1  request to send DATAIN; level-sensitive.
- DATAIN  in  24  command word, sent MSB first.
- MISO  in  1  serial data from ADC (DOUT).
- CS  out  1  chip select, active low.
- SCLK  out  1  serial clock, idles low (SPI mode 0).
- MOSI  out  1  serial data to ADC (DIN).
- RX  out  64  last read result, first received bit in RX[63].
- RX_READY  out  1  one-CLK pulse when RX updates.
- TX_SENT  out  1  high = idle and ready to accept a write; low while any transaction is in progress.

Behaviour:
- One clock domain: CLK. Reset is synchronous and active-high on RST.
- Reset (any state, including mid-transfer):
  - CS=1, SCLK=0, MOSI=0, RX=0, RX_READY=0, TX_SENT=1.
  - Pending-read flag cleared; state goes to IDLE.
- EOC handling:
  - EOC passes through a 2-flop synchronizer.
  - A falling edge of the synchronized EOC sets the pending-read flag.
  - The flag clears when the read transaction starts.
  - Multiple falling edges while pending collapse into one read.
- States: IDLE, SHIFT, TAIL, GAP.
- IDLE arbitration, one decision per CLK:
  - Pending read has priority: load shift register with {RD_CMD, 64'h0}, N=72, mode=read.
  - Otherwise, if TX_READY=1: latch DATAIN, N=24, mode=write.
  - In the start cycle: CS=0, MOSI=MSB, SCLK=0, TX_SENT=0.
- SHIFT, per bit:
  - SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is sampled on the last CLK cycle of the high phase.
  - MOSI advances to the next bit on the CLK edge where SCLK falls.
  - After N bits, go to TAIL.
- TAIL: SCLK=0, CS=0 held for CLK_DIV cycles, then CS=1 and go to GAP.
- GAP, for CS_HIGH cycles:
  - Read mode: RX is updated from the last 64 sampled bits and RX_READY pulses in the first GAP cycle.
  - At the end of GAP, return to IDLE with TX_SENT=1.
- Duration from start cycle to TX_SENT=1: N*2*CLK_DIV + CLK_DIV + CS_HIGH cycles.
  - Defaults: write = 102 cycles, read = 294 cycles.
- RX holds its value until the next read completes. It is not updated by writes.
- MOSI is 0 during the data phase of reads (after RD_CMD).
- TX_READY held high re-triggers a new write on every return to IDLE. Callers deassert it after TX_SENT falls.
- TX_READY and DATAIN are ignored outside IDLE. DATAIN changes during a transfer do not affect it.
- An EOC falling edge during a write sets the pending flag; the read starts at the next IDLE, ahead of any waiting write.

Decomposition:
- Package max11043_pkg:
  - State enum {IDLE, SHIFT, TAIL, GAP}.
  - Constants WR_BITS=24, RD_BITS=64, CMD_BITS=8, RD_CMD default.
- One sub-module, spi_bit_engine:
  - Generates SCLK from CLK_DIV.
  - Shifts MOSI and samples MISO for a given N.
  - Asserts a done strobe.
- The top of the block holds the EOC synchronizer, arbitration, CS/GAP timing and the RX register.

Test Plan:
- Reset: assert RST for 3 cycles mid-read → next cycle CS=1, SCLK=0, RX=0, TX_SENT=1; no RX_READY ever pulses for the aborted read.
- Write: DATAIN=24'h30101B, TX_READY pulsed 1 cycle while idle → capture 24 bits on SCLK rising = 0x30101B; 24 SCLK pulses; TX_SENT low for exactly 102 cycles; CS low for 98 cycles.
- Read: EOC driven low with MISO model returning 64'h123456789ABCDEF0 → MOSI first byte = 0x81; 72 SCLK pulses; RX=64'h123456789ABCDEF0; single-cycle RX_READY.
- Collision: EOC falls 10 cycles into a write of 24'h34101B → write completes intact; after the CS_HIGH gap, a read starts even with TX_READY=1.
- Back-to-back: four writes 30101B/34101B/38101B/3C101B, each issued when TX_SENT=1 → four distinct CS-low windows separated by ≥4 cycles high; all payloads correct.
- EOC glitch: two EOC falling edges during one transfer → exactly one read afterwards.
